mem_port_arbiter: RTL and testbench

Sequencer and arbiter that shares one fixed-latency memory port between the CPU's instruction-fetch stage (IF) and data-memory stage (DM). It accepts one outstanding transaction at a time, picks between simultaneous requesters round-robin, and sequences the memory access through a latency counter. It returns read data or a write acknowledge to the winning requester. It drives a pipeline stall line so the PC and pipeline registers hold while any access is pending.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/rr_pick2.sv | 22 ++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_e;

    // Requester ids; also the encoding of owner and last_gnt.
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins, on a tie the
// requester not granted last wins.
module rr_pick2 import mem_arb_pkg::*; (
    input  logic       req_if_i,
    input  logic       req_dm_i,
    input  logic       last_gnt_i,
    output logic [1:0] gnt_o       // bit 0 = IF, bit 1 = DM
);

    // One-hot pick from the current requests and the previous winner.
    always_comb begin
        gnt_o = 2'b00;
        if (req_if_i && req_dm_i) begin
            gnt_o = (last_gnt_i == REQ_IF) ? 2'b10 : 2'b01;
        end else if (req_if_i) begin
            gnt_o = 2'b01;
        end else if (req_dm_i) begin
            gnt_o = 2'b10;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data
// memory; one outstanding access, round-robin on ties, pipeline stall output.
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_valid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_valid_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_o
);

    localparam int unsigned    CntW    = $clog2(MEM_LAT + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LAT - 1);

    arb_state_e        state_q;
    logic              owner_q;
    logic              last_gnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CntW-1:0]   cnt_q;
    logic              mem_req_q;
    logic              if_valid_q;
    logic              dm_valid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic [1:0] pick;
    logic       idle;
    logic       gnt_if;
    logic       gnt_dm;

    rr_pick2 u_pick (
        .req_if_i   (if_req_i),
        .req_dm_i   (dm_req_i),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (pick)
    );

    // Grants only in IDLE; gated by reset so every output is 0 while held.
    always_comb begin
        idle   = (state_q == StIdle);
        gnt_if = pick[0] & idle & rst_i;
        gnt_dm = pick[1] & idle & rst_i;
    end

    // Sequencer: latch the winner, strobe memory, count latency, respond.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            owner_q    <= REQ_IF;
            last_gnt_q <= REQ_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            mem_req_q  <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (gnt_if || gnt_dm) begin
                        owner_q    <= gnt_dm ? REQ_DM : REQ_IF;
                        last_gnt_q <= gnt_dm ? REQ_DM : REQ_IF;
                        we_q       <= gnt_dm & dm_we_i;
                        addr_q     <= gnt_dm ? dm_addr_i : if_addr_i;
                        wdata_q    <= gnt_dm ? dm_wdata_i : '0;
                        mem_req_q  <= 1'b1;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= CntLoad;
                    state_q <= StWait;
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        // Writes leave the requester's rdata untouched.
                        if (!we_q) begin
                            if (owner_q == REQ_DM) dm_rdata_q <= mem_rdata_i;
                            else                   if_rdata_q <= mem_rdata_i;
                        end
                        if (owner_q == REQ_DM) dm_valid_q <= 1'b1;
                        else                   if_valid_q <= 1'b1;
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output drive from the registered state.
    always_comb begin
        if_gnt_o    = gnt_if;
        dm_gnt_o    = gnt_dm;
        if_valid_o  = if_valid_q;
        dm_valid_o  = dm_valid_q;
        if_rdata_o  = if_rdata_q;
        dm_rdata_o  = dm_rdata_q;
        mem_req_o   = mem_req_q;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        stall_o     = rst_i & ((if_req_i & ~if_valid_q) | (dm_req_i & ~dm_valid_q));
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiters (MEM_LAT 2 and 1) share stimulus, each with
// its own fixed-latency memory model; checks follow the protocol timing rules.
module tb_mem_port_arbiter;

    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;

    logic        if_gnt_a, if_valid_a, dm_gnt_a, dm_valid_a, mem_req_a, mem_we_a, stall_a;
    logic [31:0] if_rdata_a, dm_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a = '0;
    logic        if_gnt_b, if_valid_b, dm_gnt_b, dm_valid_b, mem_req_b, mem_we_b, stall_b;
    logic [31:0] if_rdata_b, dm_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b = '0;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_if_rd, exp_dm_rd;

    mem_port_arbiter #(.MEM_LAT(LAT_A), .ADDR_W(32), .DATA_W(32)) u_dut_a (
        .clk_i(clk), .rst_i(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_a),
        .if_valid_o(if_valid_a), .if_rdata_o(if_rdata_a),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_gnt_o(dm_gnt_a), .dm_valid_o(dm_valid_a), .dm_rdata_o(dm_rdata_a),
        .mem_req_o(mem_req_a), .mem_we_o(mem_we_a), .mem_addr_o(mem_addr_a),
        .mem_wdata_o(mem_wdata_a), .mem_rdata_i(mem_rdata_a), .stall_o(stall_a)
    );

    mem_port_arbiter #(.MEM_LAT(LAT_B), .ADDR_W(32), .DATA_W(32)) u_dut_b (
        .clk_i(clk), .rst_i(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_b),
        .if_valid_o(if_valid_b), .if_rdata_o(if_rdata_b),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_gnt_o(dm_gnt_b), .dm_valid_o(dm_valid_b), .dm_rdata_o(dm_rdata_b),
        .mem_req_o(mem_req_b), .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b),
        .mem_wdata_o(mem_wdata_b), .mem_rdata_i(mem_rdata_b), .stall_o(stall_b)
    );

    // Memory contents as a pure function of address.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
    endfunction

    // Fixed-latency memories: data is valid only in the cycle exactly LAT after
    // the strobe, random garbage otherwise.
    typedef struct { int due; logic [31:0] data; } rsp_t;
    rsp_t q_a[$];
    rsp_t q_b[$];
    int   mc = 0;

    always @(negedge clk) begin
        mc++;
        if (!rst_n) begin
            q_a.delete();
            q_b.delete();
        end
        if (mem_req_a && !mem_we_a) q_a.push_back('{due: mc + LAT_A, data: mem_model(mem_addr_a)});
        if (mem_req_b && !mem_we_b) q_b.push_back('{due: mc + LAT_B, data: mem_model(mem_addr_b)});
        while (q_a.size() > 0 && q_a[0].due < mc) void'(q_a.pop_front());
        while (q_b.size() > 0 && q_b[0].due < mc) void'(q_b.pop_front());
        if (q_a.size() > 0 && q_a[0].due == mc) begin
            mem_rdata_a <= q_a[0].data;
            void'(q_a.pop_front());
        end else begin
            mem_rdata_a <= $urandom;
        end
        if (q_b.size() > 0 && q_b[0].due == mc) begin
            mem_rdata_b <= q_b[0].data;
            void'(q_b.pop_front());
        end else begin
            mem_rdata_b <= $urandom;
        end
    end

    task automatic idle_gap(input int n);
        if_req = 1'b0;
        dm_req = 1'b0;
        dm_we  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        if_req = 1'b0;
        dm_req = 1'b0;
        dm_we  = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
        if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
        #1;
        tests_run++;
        if ({if_gnt_a, dm_gnt_a, stall_a} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_comb got=%b exp=000", {if_gnt_a, dm_gnt_a, stall_a});
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if ({if_valid_a, dm_valid_a, mem_req_a, mem_we_a} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ctrl got=%b exp=0000",
                     {if_valid_a, dm_valid_a, mem_req_a, mem_we_a});
        end
        tests_run++;
        if ({if_rdata_a, dm_rdata_a, mem_addr_a, mem_wdata_a} !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_data got=%h exp=0",
                     {if_rdata_a, dm_rdata_a, mem_addr_a, mem_wdata_a});
        end
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({if_gnt_a, dm_gnt_a, mem_req_a, stall_a} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_release got=%b exp=0000", {if_gnt_a, dm_gnt_a, mem_req_a, stall_a});
        end
    endtask

    task automatic test_lone_if_read();
        idle_gap(3);
        if_addr = 32'h100;
        if_req  = 1'b1;
        for (int t = 0; t <= LAT_A + 2; t++) begin
            if (t > 0) @(negedge clk); else #1;
            tests_run++;
            if ({if_gnt_a, dm_gnt_a, mem_req_a} !== {t == 0, 1'b0, t == 1}) begin
                tests_failed++;
                $display("FAIL lone_gnt_req t=%0d got=%b exp=%b", t,
                         {if_gnt_a, dm_gnt_a, mem_req_a}, {t == 0, 1'b0, t == 1});
            end
            tests_run++;
            if ({if_valid_a, stall_a} !== {t == LAT_A + 2, t < LAT_A + 2}) begin
                tests_failed++;
                $display("FAIL lone_valid_stall t=%0d got=%b exp=%b", t,
                         {if_valid_a, stall_a}, {t == LAT_A + 2, t < LAT_A + 2});
            end
            if (t == 1) begin
                tests_run++;
                if ({mem_we_a, mem_addr_a} !== {1'b0, 32'h100}) begin
                    tests_failed++;
                    $display("FAIL lone_mem_addr got=%h exp=%h", {mem_we_a, mem_addr_a},
                             {1'b0, 32'h100});
                end
            end
            if (t == LAT_A + 2) begin
                tests_run++;
                if (if_rdata_a !== 32'hDEAD_BEEF) begin
                    tests_failed++;
                    $display("FAIL lone_rdata got=%h exp=deadbeef", if_rdata_a);
                end
            end
        end
        if_req = 1'b0;
    endtask

    task automatic test_tie_after_reset();
        logic [31:0] ia, da;
        int          p, r;
        logic        eig, edg, eiv, edv;
        do_reset();
        ia = $urandom; da = $urandom;
        if_addr = ia; dm_addr = da; dm_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        // Both keep requesting: grants every LAT+3 cycles, alternating from DM.
        for (int t = 0; t <= 2 * (LAT_A + 3) + LAT_A + 2; t++) begin
            if (t > 0) @(negedge clk); else #1;
            p = t % (LAT_A + 3);
            r = t / (LAT_A + 3);
            edg = (p == 0) && (r % 2 == 0);
            eig = (p == 0) && (r % 2 == 1);
            edv = (p == LAT_A + 2) && (r % 2 == 0);
            eiv = (p == LAT_A + 2) && (r % 2 == 1);
            tests_run++;
            if ({if_gnt_a, dm_gnt_a} !== {eig, edg}) begin
                tests_failed++;
                $display("FAIL tie_gnt t=%0d got=%b exp=%b", t, {if_gnt_a, dm_gnt_a}, {eig, edg});
            end
            tests_run++;
            if ({if_valid_a, dm_valid_a} !== {eiv, edv}) begin
                tests_failed++;
                $display("FAIL tie_valid t=%0d got=%b exp=%b", t,
                         {if_valid_a, dm_valid_a}, {eiv, edv});
            end
            if (edv) begin
                tests_run++;
                if (dm_rdata_a !== mem_model(da)) begin
                    tests_failed++;
                    $display("FAIL tie_dm_rdata t=%0d got=%h exp=%h", t, dm_rdata_a, mem_model(da));
                end
            end
            if (eiv) begin
                tests_run++;
                if (if_rdata_a !== mem_model(ia)) begin
                    tests_failed++;
                    $display("FAIL tie_if_rdata t=%0d got=%h exp=%h", t, if_rdata_a, mem_model(ia));
                end
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        exp_dm_rd = mem_model(da);
    endtask

    task automatic test_dm_write();
        idle_gap(3);
        dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h55;
        dm_req = 1'b1;
        for (int t = 0; t <= LAT_A + 2; t++) begin
            if (t > 0) @(negedge clk); else #1;
            tests_run++;
            if ({dm_gnt_a, mem_req_a, dm_valid_a, stall_a} !==
                {t == 0, t == 1, t == LAT_A + 2, t < LAT_A + 2}) begin
                tests_failed++;
                $display("FAIL wr_ctrl t=%0d got=%b exp=%b", t,
                         {dm_gnt_a, mem_req_a, dm_valid_a, stall_a},
                         {t == 0, t == 1, t == LAT_A + 2, t < LAT_A + 2});
            end
            if (t == 1) begin
                tests_run++;
                if ({mem_we_a, mem_addr_a, mem_wdata_a} !== {1'b1, 32'h20, 32'h55}) begin
                    tests_failed++;
                    $display("FAIL wr_mem got=%h exp=%h", {mem_we_a, mem_addr_a, mem_wdata_a},
                             {1'b1, 32'h20, 32'h55});
                end
            end
            if (t == LAT_A + 2) begin
                tests_run++;
                if (dm_rdata_a !== exp_dm_rd) begin
                    tests_failed++;
                    $display("FAIL wr_rdata_kept got=%h exp=%h", dm_rdata_a, exp_dm_rd);
                end
            end
        end
        dm_req = 1'b0; dm_we = 1'b0;
    endtask

    task automatic test_withdrawal();
        idle_gap(3);
        dm_addr = $urandom; dm_we = 1'b0;
        dm_req = 1'b1;
        for (int t = 0; t <= 10; t++) begin
            if (t > 0) @(negedge clk); else #1;
            tests_run++;
            if ({if_gnt_a, mem_req_a, dm_valid_a} !== {1'b0, t == 1, t == LAT_A + 2}) begin
                tests_failed++;
                $display("FAIL withdraw t=%0d got=%b exp=%b", t, {if_gnt_a, mem_req_a, dm_valid_a},
                         {1'b0, t == 1, t == LAT_A + 2});
            end
            if (t == 1) begin
                if_addr = $urandom;
                if_req  = 1'b1;
            end
            if (t == 3) if_req = 1'b0;
            if (t == LAT_A + 2) dm_req = 1'b0;
        end
    endtask

    task automatic test_lat1();
        do_reset();
        if_addr = 32'h100;
        if_req  = 1'b1;
        for (int t = 0; t <= LAT_B + 2; t++) begin
            if (t > 0) @(negedge clk); else #1;
            tests_run++;
            if ({if_gnt_b, mem_req_b, if_valid_b, stall_b} !==
                {t == 0, t == 1, t == LAT_B + 2, t < LAT_B + 2}) begin
                tests_failed++;
                $display("FAIL lat1_ctrl t=%0d got=%b exp=%b", t,
                         {if_gnt_b, mem_req_b, if_valid_b, stall_b},
                         {t == 0, t == 1, t == LAT_B + 2, t < LAT_B + 2});
            end
            if (t == LAT_B + 2) begin
                tests_run++;
                if (if_rdata_b !== 32'hDEAD_BEEF) begin
                    tests_failed++;
                    $display("FAIL lat1_rdata got=%h exp=deadbeef", if_rdata_b);
                end
            end
        end
        if_req = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] da;
        idle_gap(3);
        if_addr = 32'h100 + ($urandom_range(1, 60) * 4);
        if_req  = 1'b1;
        #1;
        tests_run++;
        if (if_gnt_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstwait_gnt got=%b exp=1", if_gnt_a);
        end
        repeat (2) @(negedge clk);
        da = $urandom;
        dm_addr = da; dm_we = 1'b0; dm_req = 1'b1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({if_gnt_a, dm_gnt_a, if_valid_a, dm_valid_a, mem_req_a, mem_we_a, stall_a} !== 7'h0) begin
            tests_failed++;
            $display("FAIL rstwait_ctrl got=%b exp=0",
                     {if_gnt_a, dm_gnt_a, if_valid_a, dm_valid_a, mem_req_a, mem_we_a, stall_a});
        end
        tests_run++;
        if ({if_rdata_a, dm_rdata_a, mem_addr_a, mem_wdata_a} !== 128'h0) begin
            tests_failed++;
            $display("FAIL rstwait_data got=%h exp=0",
                     {if_rdata_a, dm_rdata_a, mem_addr_a, mem_wdata_a});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if ({if_gnt_a, dm_gnt_a} !== 2'b01) begin
            tests_failed++;
            $display("FAIL rstwait_tie got=%b exp=01", {if_gnt_a, dm_gnt_a});
        end
        for (int t = 1; t <= LAT_A + 2; t++) begin
            @(negedge clk);
            tests_run++;
            if ({if_valid_a, dm_valid_a} !== {1'b0, t == LAT_A + 2}) begin
                tests_failed++;
                $display("FAIL rstwait_valid t=%0d got=%b exp=%b", t, {if_valid_a, dm_valid_a},
                         {1'b0, t == LAT_A + 2});
            end
            if (t == LAT_A + 2) begin
                tests_run++;
                if (dm_rdata_a !== mem_model(da)) begin
                    tests_failed++;
                    $display("FAIL rstwait_rdata got=%h exp=%h", dm_rdata_a, mem_model(da));
                end
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
    endtask

    task automatic test_random_traffic();
        logic [1:0]  sel;
        logic        last_if, win_dm, we_exp;
        logic [31:0] addr_exp;
        do_reset();
        last_if = 1'b1;
        exp_if_rd = '0;
        exp_dm_rd = '0;
        @(negedge clk);
        for (int n = 0; n < 40; n++) begin
            sel = 2'($urandom_range(1, 3));
            if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
            dm_we = 1'($urandom_range(0, 1));
            win_dm   = (sel == 2'b10) || (sel == 2'b11 && last_if);
            we_exp   = win_dm & dm_we;
            addr_exp = win_dm ? dm_addr : if_addr;
            if_req = sel[0]; dm_req = sel[1];
            #1;
            tests_run++;
            if ({if_gnt_a, dm_gnt_a} !== {~win_dm, win_dm}) begin
                tests_failed++;
                $display("FAIL rnd_gnt n=%0d sel=%b got=%b exp=%b", n, sel,
                         {if_gnt_a, dm_gnt_a}, {~win_dm, win_dm});
            end
            for (int t = 1; t <= LAT_A + 2; t++) begin
                @(negedge clk);
                if (t == 1) begin
                    tests_run++;
                    if ({mem_req_a, mem_we_a, mem_addr_a} !== {1'b1, we_exp, addr_exp}) begin
                        tests_failed++;
                        $display("FAIL rnd_mem n=%0d got=%h exp=%h", n,
                                 {mem_req_a, mem_we_a, mem_addr_a}, {1'b1, we_exp, addr_exp});
                    end
                    if (we_exp) begin
                        tests_run++;
                        if (mem_wdata_a !== dm_wdata) begin
                            tests_failed++;
                            $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, mem_wdata_a, dm_wdata);
                        end
                    end
                end
                if (t < LAT_A + 2) begin
                    tests_run++;
                    if ({if_valid_a, dm_valid_a, stall_a} !== 3'b001) begin
                        tests_failed++;
                        $display("FAIL rnd_busy n=%0d t=%0d got=%b exp=001", n, t,
                                 {if_valid_a, dm_valid_a, stall_a});
                    end
                end else begin
                    if (!we_exp) begin
                        if (win_dm) exp_dm_rd = mem_model(addr_exp);
                        else        exp_if_rd = mem_model(addr_exp);
                    end
                    tests_run++;
                    if ({if_valid_a, dm_valid_a} !== {~win_dm, win_dm}) begin
                        tests_failed++;
                        $display("FAIL rnd_valid n=%0d got=%b exp=%b", n,
                                 {if_valid_a, dm_valid_a}, {~win_dm, win_dm});
                    end
                    tests_run++;
                    if ({if_rdata_a, dm_rdata_a} !== {exp_if_rd, exp_dm_rd}) begin
                        tests_failed++;
                        $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n,
                                 {if_rdata_a, dm_rdata_a}, {exp_if_rd, exp_dm_rd});
                    end
                end
            end
            last_if = ~win_dm;
            if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_lone_if_read();
        test_tie_after_reset();
        test_dm_write();
        test_withdrawal();
        test_lat1();
        test_reset_in_wait();
        test_random_traffic();
        idle_gap(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
